cache_bank_sched: RTL and testbench
===================================

# cache_bank_sched

Bank input scheduler that sits directly upstream of the bank pipeline and the bank MSHR. Each cycle it arbitrates among three request sources: MSHR replay dequeues, memory fill responses and new core requests. It issues the MSHR side effects of the winner, either a fill notification or an allocate. It then loads the winner into a single registered output stage that feeds bank pipeline stage 0. A saturating starvation counter prevents sustained fill/replay traffic from locking out core requests.

## Interface
- LINE_ADDR_WIDTH, 26, bank-local line address width
- WORD_WIDTH, 32, core request data width
- LINE_WIDTH, 128, fill data width; output data width
- MSHR_ADDR_WIDTH, 2, MSHR slot id width
- TAG_WIDTH, 8, core request tag width
- STARVE_LIMIT, 8, core wait cycles before boost (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- core_valid / core_ready  in / out  1  core request handshake
- core_addr  in  LINE_ADDR_WIDTH  line address
- core_rw  in  1  1 = write
- core_data  in  WORD_WIDTH  write data
- core_tag  in  TAG_WIDTH  request tag
- fill_rsp_valid / fill_rsp_ready  in / out  1  memory response handshake
- fill_rsp_id  in  MSHR_ADDR_WIDTH  MSHR id of the response
- fill_rsp_data  in  LINE_WIDTH  line data
- rep_valid / rep_ready  in / out  1  MSHR dequeue handshake
- rep_addr, rep_rw, rep_data, rep_id  in  LINE_ADDR_WIDTH, 1, WORD_WIDTH, MSHR_ADDR_WIDTH  replay payload
- mshr_fill_valid  out  1  fill notification to MSHR
- mshr_fill_id  out  MSHR_ADDR_WIDTH  equals fill_rsp_id
- mshr_fill_addr  in  LINE_ADDR_WIDTH  MSHR lookup of fill id, combinational
- mshr_alloc_valid  out  1  allocate strobe
- mshr_alloc_addr, mshr_alloc_rw  out  LINE_ADDR_WIDTH, 1  allocate payload (equal to core_addr, core_rw)
- mshr_alloc_ready  in  1  MSHR has a free slot
- mshr_alloc_id  in  MSHR_ADDR_WIDTH  allocated slot
- pipe_valid / pipe_ready  out / in  1  output stage handshake
- pipe_type  out  2  0 = core, 1 = fill, 2 = replay
- pipe_addr, pipe_rw  out  LINE_ADDR_WIDTH, 1  request payload
- pipe_data  out  LINE_WIDTH  request data
- pipe_mshr_id  out  MSHR_ADDR_WIDTH  MSHR slot of the request
- pipe_tag  out  TAG_WIDTH  core tag; 0 for non-core

## Operation
- The output stage can load when `load_en = !pipe_valid || pipe_ready`.
- Core eligibility: `core_elig = core_valid && mshr_alloc_ready`.
- Boost: `boost = (starve_cnt == STARVE_LIMIT)`.
- Default priority is replay > fill > core. When boost is set, core is promoted to highest priority, but only if core_elig.
- Ready signals:
  - `rep_ready = load_en && !(boost && core_elig)`
  - `fill_rsp_ready = load_en && !rep_valid && !(boost && core_elig)`
  - `core_ready = load_en && mshr_alloc_ready && (boost || (!rep_valid && !fill_rsp_valid))`
- At most one of the three sources fires per cycle.
- Fill fire:
  - Drive mshr_fill_valid = 1 with mshr_fill_id = fill_rsp_id.
  - Load pipe_addr = mshr_fill_addr, pipe_data = fill_rsp_data, pipe_mshr_id = fill_rsp_id, pipe_rw = 0, pipe_type = 1.
- Core fire:
  - Drive mshr_alloc_valid = 1.
  - Load pipe_mshr_id = mshr_alloc_id, pipe_data = {zeros, core_data}, pipe_tag = core_tag, pipe_type = 0.
- Replay fire: load the rep_* payload; data is zero-extended; pipe_type = 2.
- mshr_fill_valid and mshr_alloc_valid are combinational and asserted only in the fire cycle.
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - Cleared to 0 on a core fire.
  - Otherwise incremented (saturating at STARVE_LIMIT) when core_elig && !core_ready.
  - Otherwise held.
  - Core not eligible (MSHR full) means the counter holds.
- Output stage:
  - When load_en is true and no source fires, pipe_valid goes to 0.
  - While pipe_valid && !pipe_ready, all pipe_* outputs hold stable.

## Timing
- Reset values:
  - pipe_valid = 0 and starve_cnt = 0.
  - pipe_type, pipe_addr, pipe_rw, pipe_data, pipe_mshr_id and pipe_tag are 0.
  - All ready and strobe outputs are 0 while reset is asserted.
- Latency: one cycle from source fire to pipe_valid.
- Back-to-back: with pipe_ready held at 1, one request can issue per cycle.
- Stall: with pipe_valid = 1 and pipe_ready = 0, all source readies are 0 and no MSHR strobes are driven.
- Reset mid-operation: the held request is dropped and starve_cnt is cleared.
- mshr_alloc_ready falling while core_valid: core_ready goes to 0 in the same cycle; no allocate is issued.
- Boost with MSHR full: the boost has no effect and fill/replay proceed normally.
- Simultaneous fill and replay: replay wins; fill waits.
- Boost clears the cycle after the boosted core fire.

## Test plan
- Single source, each type in turn, pipe_ready = 1 → pipe_valid on the next cycle with the correct payload.
  - Fill id 2: mshr_fill_id = 2 in the fire cycle, and pipe_addr equals the value returned on mshr_fill_addr.
- All three sources valid, pipe_ready = 1, no boost → grant order replay, then fill, then core; 3 outputs in 3 cycles.
- Continuous replay, STARVE_LIMIT = 8, core valid, MSHR not full → core fires on cycle 9; starve_cnt returns to 0; replay resumes on cycle 10.
- Same as the previous scenario but mshr_alloc_ready = 0 → core never fires, starve_cnt stays 0, mshr_alloc_valid never asserts.
- pipe_ready = 0 for 5 cycles with a fill held → pipe_* stable, all source readies 0, no MSHR strobes.
- Reset asserted with pipe_valid = 1 and starve_cnt = 5 → next cycle pipe_valid = 0 and starve_cnt = 0.

Source files
------------

// File: rtl/cache_bank_sched.sv
// Bank input scheduler: arbitrates MSHR replays, memory fills and core requests into one
// registered stage feeding bank pipeline stage 0, with a starvation boost for core traffic.
module cache_bank_sched #(
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int WORD_WIDTH      = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MSHR_ADDR_WIDTH = 2,
    parameter int TAG_WIDTH       = 8,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       core_valid_i,
    output logic                       core_ready_o,
    input  logic [LINE_ADDR_WIDTH-1:0] core_addr_i,
    input  logic                       core_rw_i,
    input  logic [WORD_WIDTH-1:0]      core_data_i,
    input  logic [TAG_WIDTH-1:0]       core_tag_i,

    input  logic                       fill_rsp_valid_i,
    output logic                       fill_rsp_ready_o,
    input  logic [MSHR_ADDR_WIDTH-1:0] fill_rsp_id_i,
    input  logic [LINE_WIDTH-1:0]      fill_rsp_data_i,

    input  logic                       rep_valid_i,
    output logic                       rep_ready_o,
    input  logic [LINE_ADDR_WIDTH-1:0] rep_addr_i,
    input  logic                       rep_rw_i,
    input  logic [WORD_WIDTH-1:0]      rep_data_i,
    input  logic [MSHR_ADDR_WIDTH-1:0] rep_id_i,

    output logic                       mshr_fill_valid_o,
    output logic [MSHR_ADDR_WIDTH-1:0] mshr_fill_id_o,
    input  logic [LINE_ADDR_WIDTH-1:0] mshr_fill_addr_i,

    output logic                       mshr_alloc_valid_o,
    output logic [LINE_ADDR_WIDTH-1:0] mshr_alloc_addr_o,
    output logic                       mshr_alloc_rw_o,
    input  logic                       mshr_alloc_ready_i,
    input  logic [MSHR_ADDR_WIDTH-1:0] mshr_alloc_id_i,

    output logic                       pipe_valid_o,
    input  logic                       pipe_ready_i,
    output logic [1:0]                 pipe_type_o,
    output logic [LINE_ADDR_WIDTH-1:0] pipe_addr_o,
    output logic                       pipe_rw_o,
    output logic [LINE_WIDTH-1:0]      pipe_data_o,
    output logic [MSHR_ADDR_WIDTH-1:0] pipe_mshr_id_o,
    output logic [TAG_WIDTH-1:0]       pipe_tag_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        TYPE_CORE   = 2'd0,
        TYPE_FILL   = 2'd1,
        TYPE_REPLAY = 2'd2
    } pipe_type_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_FILL,
        GNT_REPLAY
    } grant_e;

    logic [CNT_W-1:0]           starve_q, starve_d;
    logic                       valid_q, valid_d;
    pipe_type_e                 type_q, type_d;
    logic [LINE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       rw_q, rw_d;
    logic [LINE_WIDTH-1:0]      data_q, data_d;
    logic [MSHR_ADDR_WIDTH-1:0] id_q, id_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;

    logic   load_en;
    logic   core_elig;
    logic   boost;
    logic   core_boosted;
    logic   core_fire, fill_fire, rep_fire;
    grant_e grant;

    always_comb begin
        load_en      = !valid_q || pipe_ready_i;
        core_elig    = core_valid_i && mshr_alloc_ready_i;
        boost        = (starve_q == CNT_MAX);
        core_boosted = boost && core_elig;
    end

    // Readies are built so that at most one source can ever see valid && ready together.
    always_comb begin
        rep_ready_o      = !reset && load_en && !core_boosted;
        fill_rsp_ready_o = !reset && load_en && !rep_valid_i && !core_boosted;
        core_ready_o     = !reset && load_en && mshr_alloc_ready_i &&
                           (boost || (!rep_valid_i && !fill_rsp_valid_i));
    end

    always_comb begin
        rep_fire  = rep_valid_i && rep_ready_o;
        fill_fire = fill_rsp_valid_i && fill_rsp_ready_o;
        core_fire = core_valid_i && core_ready_o;

        grant = GNT_NONE;
        if (core_fire) begin
            grant = GNT_CORE;
        end else if (rep_fire) begin
            grant = GNT_REPLAY;
        end else if (fill_fire) begin
            grant = GNT_FILL;
        end
    end

    always_comb begin
        mshr_fill_valid_o  = fill_fire;
        mshr_fill_id_o     = fill_rsp_id_i;
        mshr_alloc_valid_o = core_fire;
        mshr_alloc_addr_o  = core_addr_i;
        mshr_alloc_rw_o    = core_rw_i;
    end

    // A core that is eligible but refused ages the counter; a full MSHR leaves it untouched.
    always_comb begin
        starve_d = starve_q;
        if (core_fire) begin
            starve_d = '0;
        end else if (core_elig && !core_ready_o && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        type_d  = type_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        data_d  = data_q;
        id_d    = id_q;
        tag_d   = tag_q;
        if (load_en) begin
            valid_d = (grant != GNT_NONE);
            unique case (grant)
                GNT_CORE: begin
                    type_d = TYPE_CORE;
                    addr_d = core_addr_i;
                    rw_d   = core_rw_i;
                    data_d = LINE_WIDTH'(core_data_i);
                    id_d   = mshr_alloc_id_i;
                    tag_d  = core_tag_i;
                end
                GNT_FILL: begin
                    type_d = TYPE_FILL;
                    addr_d = mshr_fill_addr_i;
                    rw_d   = 1'b0;
                    data_d = fill_rsp_data_i;
                    id_d   = fill_rsp_id_i;
                    tag_d  = '0;
                end
                GNT_REPLAY: begin
                    type_d = TYPE_REPLAY;
                    addr_d = rep_addr_i;
                    rw_d   = rep_rw_i;
                    data_d = LINE_WIDTH'(rep_data_i);
                    id_d   = rep_id_i;
                    tag_d  = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            valid_q  <= 1'b0;
            type_q   <= TYPE_CORE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            id_q     <= '0;
            tag_q    <= '0;
        end else begin
            starve_q <= starve_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            data_q   <= data_d;
            id_q     <= id_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        pipe_valid_o   = valid_q;
        pipe_type_o    = type_q;
        pipe_addr_o    = addr_q;
        pipe_rw_o      = rw_q;
        pipe_data_o    = data_q;
        pipe_mshr_id_o = id_q;
        pipe_tag_o     = tag_q;
    end

endmodule

// File: tb/tb_cache_bank_sched.sv
// Randomized scoreboard bench for cache_bank_sched: a priority/starvation reference model
// predicts readies, strobes and the ordered stream of requests leaving the output stage.
module tb_cache_bank_sched;

    localparam int LAW   = 26;
    localparam int WW    = 32;
    localparam int LW    = 128;
    localparam int MW    = 2;
    localparam int TW    = 8;
    localparam int LIMIT = 8;

    typedef struct {
        logic          rst;
        logic          coreValid;
        logic [LAW-1:0] coreAddr;
        logic          coreRw;
        logic [WW-1:0] coreData;
        logic [TW-1:0] coreTag;
        logic          fillValid;
        logic [MW-1:0] fillId;
        logic [LW-1:0] fillData;
        logic          repValid;
        logic [LAW-1:0] repAddr;
        logic          repRw;
        logic [WW-1:0] repData;
        logic [MW-1:0] repId;
        logic          allocReady;
        logic [MW-1:0] allocId;
        logic          pipeReady;
    } stim_t;

    typedef struct {
        logic [1:0]     ty;
        logic [LAW-1:0] addr;
        logic           rw;
        logic [LW-1:0]  data;
        logic [MW-1:0]  id;
        logic [TW-1:0]  tag;
    } item_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           core_valid_i = 1'b0, core_rw_i = 1'b0;
    logic [LAW-1:0] core_addr_i = '0;
    logic [WW-1:0]  core_data_i = '0;
    logic [TW-1:0]  core_tag_i = '0;
    logic           fill_rsp_valid_i = 1'b0;
    logic [MW-1:0]  fill_rsp_id_i = '0;
    logic [LW-1:0]  fill_rsp_data_i = '0;
    logic           rep_valid_i = 1'b0, rep_rw_i = 1'b0;
    logic [LAW-1:0] rep_addr_i = '0;
    logic [WW-1:0]  rep_data_i = '0;
    logic [MW-1:0]  rep_id_i = '0;
    logic [LAW-1:0] mshr_fill_addr_i = '0;
    logic           mshr_alloc_ready_i = 1'b0;
    logic [MW-1:0]  mshr_alloc_id_i = '0;
    logic           pipe_ready_i = 1'b0;

    logic           core_ready_o, fill_rsp_ready_o, rep_ready_o;
    logic           mshr_fill_valid_o, mshr_alloc_valid_o, mshr_alloc_rw_o;
    logic [MW-1:0]  mshr_fill_id_o;
    logic [LAW-1:0] mshr_alloc_addr_o;
    logic           pipe_valid_o, pipe_rw_o;
    logic [1:0]     pipe_type_o;
    logic [LAW-1:0] pipe_addr_o;
    logic [LW-1:0]  pipe_data_o;
    logic [MW-1:0]  pipe_mshr_id_o;
    logic [TW-1:0]  pipe_tag_o;

    cache_bank_sched #(
        .LINE_ADDR_WIDTH(LAW), .WORD_WIDTH(WW), .LINE_WIDTH(LW),
        .MSHR_ADDR_WIDTH(MW), .TAG_WIDTH(TW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .core_valid_i(core_valid_i), .core_ready_o(core_ready_o), .core_addr_i(core_addr_i),
        .core_rw_i(core_rw_i), .core_data_i(core_data_i), .core_tag_i(core_tag_i),
        .fill_rsp_valid_i(fill_rsp_valid_i), .fill_rsp_ready_o(fill_rsp_ready_o),
        .fill_rsp_id_i(fill_rsp_id_i), .fill_rsp_data_i(fill_rsp_data_i),
        .rep_valid_i(rep_valid_i), .rep_ready_o(rep_ready_o), .rep_addr_i(rep_addr_i),
        .rep_rw_i(rep_rw_i), .rep_data_i(rep_data_i), .rep_id_i(rep_id_i),
        .mshr_fill_valid_o(mshr_fill_valid_o), .mshr_fill_id_o(mshr_fill_id_o),
        .mshr_fill_addr_i(mshr_fill_addr_i),
        .mshr_alloc_valid_o(mshr_alloc_valid_o), .mshr_alloc_addr_o(mshr_alloc_addr_o),
        .mshr_alloc_rw_o(mshr_alloc_rw_o), .mshr_alloc_ready_i(mshr_alloc_ready_i),
        .mshr_alloc_id_i(mshr_alloc_id_i),
        .pipe_valid_o(pipe_valid_o), .pipe_ready_i(pipe_ready_i), .pipe_type_o(pipe_type_o),
        .pipe_addr_o(pipe_addr_o), .pipe_rw_o(pipe_rw_o), .pipe_data_o(pipe_data_o),
        .pipe_mshr_id_o(pipe_mshr_id_o), .pipe_tag_o(pipe_tag_o)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    bit        started = 1'b0;
    item_t     expQ[$];
    bit        mValid = 1'b0;
    int        mWait = 0;
    logic [LAW-1:0] fillAddrTab[4];

    task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic stim_t mkStim(input bit rv, input bit fv, input bit cv, input bit ar, input bit pr);
        stim_t s;
        s.rst        = 1'b0;
        s.coreValid  = cv;
        s.coreAddr   = LAW'($urandom);
        s.coreRw     = 1'($urandom);
        s.coreData   = $urandom;
        s.coreTag    = TW'($urandom);
        s.fillValid  = fv;
        s.fillId     = MW'($urandom);
        s.fillData   = {$urandom, $urandom, $urandom, $urandom};
        s.repValid   = rv;
        s.repAddr    = LAW'($urandom);
        s.repRw      = 1'($urandom);
        s.repData    = $urandom;
        s.repId      = MW'($urandom);
        s.allocReady = ar;
        s.allocId    = MW'($urandom);
        s.pipeReady  = pr;
        return s;
    endfunction

    // One cycle: drive at the falling edge, then predict and check the combinational response.
    task automatic applyStimulus(input stim_t s);
        bit    canLoad, elig, boosted, expRep, expFill, expCore;
        int    win;
        item_t it;
        @(negedge clk);
        reset              = s.rst;
        core_valid_i       = s.coreValid;
        core_addr_i        = s.coreAddr;
        core_rw_i          = s.coreRw;
        core_data_i        = s.coreData;
        core_tag_i         = s.coreTag;
        fill_rsp_valid_i   = s.fillValid;
        fill_rsp_id_i      = s.fillId;
        fill_rsp_data_i    = s.fillData;
        mshr_fill_addr_i   = fillAddrTab[s.fillId];
        rep_valid_i        = s.repValid;
        rep_addr_i         = s.repAddr;
        rep_rw_i           = s.repRw;
        rep_data_i         = s.repData;
        rep_id_i           = s.repId;
        mshr_alloc_ready_i = s.allocReady;
        mshr_alloc_id_i    = s.allocId;
        pipe_ready_i       = s.pipeReady;
        #2;
        if (s.rst) begin
            checkOutput("rst_core_ready", LW'(core_ready_o), '0);
            checkOutput("rst_fill_ready", LW'(fill_rsp_ready_o), '0);
            checkOutput("rst_rep_ready", LW'(rep_ready_o), '0);
            checkOutput("rst_fill_strobe", LW'(mshr_fill_valid_o), '0);
            checkOutput("rst_alloc_strobe", LW'(mshr_alloc_valid_o), '0);
            expQ.delete();
            mValid  = 1'b0;
            mWait   = 0;
            started = 1'b1;
        end else begin
            canLoad = !mValid || s.pipeReady;
            elig    = s.coreValid && s.allocReady;
            boosted = (mWait == LIMIT);
            if (!canLoad)               win = 0;
            else if (boosted && elig)   win = 1;
            else if (s.repValid)        win = 3;
            else if (s.fillValid)       win = 2;
            else if (elig)              win = 1;
            else                        win = 0;
            expRep  = canLoad && !(boosted && elig);
            expFill = canLoad && !s.repValid && !(boosted && elig);
            expCore = canLoad && s.allocReady && (boosted || (!s.repValid && !s.fillValid));

            checkOutput("rep_ready", LW'(rep_ready_o), LW'(expRep));
            checkOutput("fill_ready", LW'(fill_rsp_ready_o), LW'(expFill));
            checkOutput("core_ready", LW'(core_ready_o), LW'(expCore));
            checkOutput("fill_strobe", LW'(mshr_fill_valid_o), LW'(win == 2));
            checkOutput("alloc_strobe", LW'(mshr_alloc_valid_o), LW'(win == 1));
            if (win == 2) checkOutput("fill_id", LW'(mshr_fill_id_o), LW'(s.fillId));
            if (win == 1) begin
                checkOutput("alloc_addr", LW'(mshr_alloc_addr_o), LW'(s.coreAddr));
                checkOutput("alloc_rw", LW'(mshr_alloc_rw_o), LW'(s.coreRw));
            end

            if (win == 1) begin
                it = '{2'd0, s.coreAddr, s.coreRw, LW'(s.coreData), s.allocId, s.coreTag};
            end else if (win == 2) begin
                it = '{2'd1, fillAddrTab[s.fillId], 1'b0, s.fillData, s.fillId, '0};
            end else begin
                it = '{2'd2, s.repAddr, s.repRw, LW'(s.repData), s.repId, '0};
            end
            if (win != 0) expQ.push_back(it);

            if (win == 1) mWait = 0;
            else if (elig && !expCore && mWait < LIMIT) mWait++;
            if (canLoad) mValid = (win != 0);
        end
    endtask

    // Monitor: compares the presented request with the oldest expected one, retires it on handshake.
    item_t mon;
    always begin
        @(negedge clk);
        #1;
        if (started && !reset) begin
            checkOutput("pipe_valid", LW'(pipe_valid_o), LW'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                mon = expQ[0];
                checkOutput("pipe_type", LW'(pipe_type_o), LW'(mon.ty));
                checkOutput("pipe_addr", LW'(pipe_addr_o), LW'(mon.addr));
                checkOutput("pipe_rw", LW'(pipe_rw_o), LW'(mon.rw));
                checkOutput("pipe_data", pipe_data_o, mon.data);
                checkOutput("pipe_mshr_id", LW'(pipe_mshr_id_o), LW'(mon.id));
                checkOutput("pipe_tag", LW'(pipe_tag_o), LW'(mon.tag));
                if (pipe_ready_i) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 4; i++) fillAddrTab[i] = LAW'($urandom);

        s = mkStim(0, 0, 0, 1, 1);
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        $display("[TB] single-source requests");
        applyStimulus(mkStim(0, 0, 1, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));
        s = mkStim(0, 1, 0, 1, 1);
        s.fillId = 2'd2;
        applyStimulus(s);
        applyStimulus(mkStim(0, 0, 0, 1, 1));
        applyStimulus(mkStim(1, 0, 0, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));

        $display("[TB] three sources competing");
        applyStimulus(mkStim(1, 1, 1, 1, 1));
        applyStimulus(mkStim(0, 1, 1, 1, 1));
        applyStimulus(mkStim(0, 0, 1, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));

        $display("[TB] continuous replay with waiting core");
        for (int i = 0; i < 12; i++) applyStimulus(mkStim(1, 0, 1, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));

        $display("[TB] continuous replay with MSHR full");
        for (int i = 0; i < 12; i++) applyStimulus(mkStim(1, 0, 1, 0, 1));
        for (int i = 0; i < 10; i++) applyStimulus(mkStim(1, 0, 1, 1, 1));

        $display("[TB] output stall holding a fill");
        applyStimulus(mkStim(0, 1, 0, 1, 1));
        for (int i = 0; i < 5; i++)
            applyStimulus(mkStim(1'($urandom), 1, 1, 1, 0));
        applyStimulus(mkStim(0, 0, 0, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));

        $display("[TB] reset with a held request and partial starvation");
        for (int i = 0; i < 5; i++) applyStimulus(mkStim(1, 0, 1, 1, 1));
        s = mkStim(1, 0, 1, 1, 0);
        s.rst = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 11; i++) applyStimulus(mkStim(1, 0, 1, 1, 1));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            s = mkStim($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                       $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8,
                       $urandom_range(0, 9) < 7);
            s.rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) fillAddrTab[$urandom_range(0, 3)] = LAW'($urandom);
            applyStimulus(s);
        end
        applyStimulus(mkStim(0, 0, 0, 1, 1));
        applyStimulus(mkStim(0, 0, 0, 1, 1));

        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
